// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA widths, padding constants and padder state encoding
package sha_pkg;

   localparam int SHA_BLOCK_W = 512;
   localparam int SHA_WORD_W  = 32;
   localparam int SHA_LEN_W   = 64;
   localparam logic [7:0] SHA_PAD_BYTE = 8'h80;
   // Last byte at an index below this leaves room for the length in the same block
   localparam logic [5:0] LEN_LIMIT = 6'd55;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      EMIT  = 2'd1,
      LEN   = 2'd2
   } pad_state_t;

   // Bit offset of message byte n within a block: word n/4, big-endian lane 3-(n%4)
   function automatic logic [8:0] byte_pos(input logic [5:0] n);
      return {n[5:2], 5'd0} + {4'd0, ~n[1:0], 3'd0};
   endfunction

endpackage

// File: rtl/sha_padder_if.sv
// rtl/sha_padder_if.sv - byte-in / block-out handshake bundle for sha_padder
// SHA_PAD_FIRST_EN adds block_first_p (first block of a message).
interface sha_padder_if;
   import sha_pkg::*;

   logic [7:0]             data_p;
   logic                   data_valid_p;
   logic                   data_last_p;
   logic                   data_ready_p;
   logic [SHA_BLOCK_W-1:0] block_p;
   logic                   block_valid_p;
   logic                   block_ready_p;
   logic                   block_last_p;
`ifdef SHA_PAD_FIRST_EN
   logic                   block_first_p;

   modport slave (
      input  data_p, data_valid_p, data_last_p, block_ready_p,
      output data_ready_p, block_p, block_valid_p, block_last_p, block_first_p
   );

   modport master (
      output data_p, data_valid_p, data_last_p, block_ready_p,
      input  data_ready_p, block_p, block_valid_p, block_last_p, block_first_p
   );
`else
   modport slave (
      input  data_p, data_valid_p, data_last_p, block_ready_p,
      output data_ready_p, block_p, block_valid_p, block_last_p
   );

   modport master (
      output data_p, data_valid_p, data_last_p, block_ready_p,
      input  data_ready_p, block_p, block_valid_p, block_last_p
   );
`endif

endinterface

// File: rtl/sha_padder.sv
// rtl/sha_padder.sv - SHA-256 message padder: bytes in, padded 512-bit blocks out
// SHA_PAD_FIRST_EN enables block_first_p for hash-core IV reload.
module sha_padder
   import sha_pkg::*;
(
   input  logic        clk_p,
   input  logic        reset_p,
   sha_padder_if.slave bus
);

   pad_state_t             state_q, state_d;
   logic [SHA_BLOCK_W-1:0] buf_q, buf_d;
   logic [SHA_LEN_W-1:0]   cnt_q, cnt_d;
   logic [5:0]             idx_q, idx_d;
   logic                   len_pend_q, len_pend_d;
   logic                   len_pad_q, len_pad_d;
   logic                   last_q, last_d;
`ifdef SHA_PAD_FIRST_EN
   logic                   started_q, started_d;
`endif

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      len_pend_d = len_pend_q;
      len_pad_d  = len_pad_q;
      last_d     = last_q;
`ifdef SHA_PAD_FIRST_EN
      started_d  = started_q;
`endif
      case (state_q)
         ACCUM: begin
            if (bus.data_valid_p) begin
               buf_d[byte_pos(idx_q) +: 8] = bus.data_p;
               cnt_d = cnt_q + 64'd8;
               idx_d = idx_q + 6'd1;
               if (bus.data_last_p) begin
                  if (idx_q != 6'd63)
                     buf_d[byte_pos(idx_q + 6'd1) +: 8] = SHA_PAD_BYTE;
                  if (idx_q < LEN_LIMIT) begin
                     buf_d[SHA_BLOCK_W-1 -: SHA_LEN_W] =
                        {cnt_d[SHA_WORD_W-1:0], cnt_d[SHA_LEN_W-1:SHA_WORD_W]};
                     last_d = 1'b1;
                  end else begin
                     len_pend_d = 1'b1;
                     len_pad_d  = (idx_q == 6'd63);
                     last_d     = 1'b0;
                  end
                  state_d = EMIT;
               end else if (idx_q == 6'd63) begin
                  last_d  = 1'b0;
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (bus.block_ready_p) begin
               idx_d = '0;
               buf_d = '0;
               if (len_pend_q) begin
                  // Trailing length-only block; carries the pad marker if the message filled the block
                  if (len_pad_q)
                     buf_d[SHA_WORD_W-1 -: 8] = SHA_PAD_BYTE;
                  buf_d[SHA_BLOCK_W-1 -: SHA_LEN_W] =
                     {cnt_q[SHA_WORD_W-1:0], cnt_q[SHA_LEN_W-1:SHA_WORD_W]};
                  last_d     = 1'b1;
                  len_pend_d = 1'b0;
                  len_pad_d  = 1'b0;
                  state_d    = LEN;
               end else begin
                  if (last_q)
                     cnt_d = '0;
                  last_d  = 1'b0;
                  state_d = ACCUM;
               end
`ifdef SHA_PAD_FIRST_EN
               started_d = !last_q;
`endif
            end
         end
         LEN: begin
            if (bus.block_ready_p) begin
               buf_d   = '0;
               cnt_d   = '0;
               last_d  = 1'b0;
               state_d = ACCUM;
`ifdef SHA_PAD_FIRST_EN
               started_d = 1'b0;
`endif
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk_p or posedge reset_p) begin
      if (reset_p) begin
         state_q    <= ACCUM;
         buf_q      <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         len_pend_q <= 1'b0;
         len_pad_q  <= 1'b0;
         last_q     <= 1'b0;
`ifdef SHA_PAD_FIRST_EN
         started_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         len_pend_q <= len_pend_d;
         len_pad_q  <= len_pad_d;
         last_q     <= last_d;
`ifdef SHA_PAD_FIRST_EN
         started_q  <= started_d;
`endif
      end
   end

   assign bus.data_ready_p  = (state_q == ACCUM);
   assign bus.block_valid_p = (state_q != ACCUM);
   assign bus.block_p       = buf_q;
   assign bus.block_last_p  = last_q;
`ifdef SHA_PAD_FIRST_EN
   assign bus.block_first_p = (state_q == EMIT) && !started_q;
`endif

endmodule

// File: tb/tb_sha_padder.sv
// tb/tb_sha_padder.sv - self-checking bench for sha_padder against a byte-level SHA padding model
// SHA_PAD_FIRST_EN additionally checks block_first_p.
module tb_sha_padder;
   import sha_pkg::*;

   logic clk_p = 1'b0;
   logic reset_p = 1'b1;

   sha_padder_if bus();

   sha_padder dut (
      .clk_p   (clk_p),
      .reset_p (reset_p),
      .bus     (bus)
   );

   always #5 clk_p = ~clk_p;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk_p) cyc <= cyc + 1;

   logic [7:0]   msg_q[$];
   logic [511:0] got_blk[$], exp_blk[$];
   bit           got_last[$], exp_last[$], got_first[$], exp_first[$];
   int           hold_viol, drv_sent, drv_cycles, t_last, t_valid;

   localparam logic [511:0] ABCD_BLK =
      {32'h00000020, 32'h0, {12{32'h0}}, 32'h80000000, 32'h61626364};

   task automatic build_exp();
      logic [7:0]   p[$];
      logic [63:0]  bits;
      logic [511:0] blk;
      int           nb;
      exp_blk.delete(); exp_last.delete(); exp_first.delete();
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg_q.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      nb = p.size() / 64;
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int w = 0; w < 16; w++)
            blk[32*w +: 32] = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
         exp_blk.push_back(blk);
         exp_last.push_back(b == nb - 1);
         exp_first.push_back(b == 0);
      end
   endtask

   task automatic drive(input int valid_pct);
      int i = 0;
      int n = msg_q.size();
      bit v, rdy;
      drv_cycles = 0;
      while (i < n && drv_cycles < 3000) begin
         @(negedge clk_p);
         v = (int'($urandom_range(99)) < valid_pct);
         bus.data_valid_p = v;
         bus.data_p       = v ? msg_q[i] : 8'($urandom);
         bus.data_last_p  = v ? (i == n - 1) : 1'($urandom);
         rdy = bus.data_ready_p;
         if (v && rdy && i == n - 1) t_last = cyc;
         @(posedge clk_p);
         drv_cycles++;
         if (v && rdy) i++;
      end
      drv_sent = i;
      @(negedge clk_p);
      bus.data_valid_p = 1'b0;
      bus.data_last_p  = 1'b0;
   endtask

   task automatic collect(input int n_exp, input int ready_pct, input int stall);
      int           stall_left = stall;
      int           budget = 0;
      bit           pend = 0, r, pl;
      logic [511:0] pb;
      got_blk.delete(); got_last.delete(); got_first.delete();
      hold_viol = 0;
      t_valid   = -1;
      while (got_blk.size() < n_exp && budget < 6000) begin
         @(negedge clk_p);
         if (pend && (!bus.block_valid_p || bus.block_p !== pb || bus.block_last_p !== pl))
            hold_viol++;
         if (bus.block_valid_p && bus.data_ready_p) hold_viol++;
         if (bus.block_valid_p && t_valid < 0) t_valid = cyc;
         if (bus.block_valid_p && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
         end else begin
            r = (int'($urandom_range(99)) < ready_pct);
         end
         bus.block_ready_p = r;
         if (bus.block_valid_p && r) begin
            got_blk.push_back(bus.block_p);
            got_last.push_back(bus.block_last_p);
`ifdef SHA_PAD_FIRST_EN
            got_first.push_back(bus.block_first_p);
`else
            got_first.push_back(1'b0);
`endif
            pend = 1'b0;
         end else begin
            pend = bus.block_valid_p;
         end
         pb = bus.block_p;
         pl = bus.block_last_p;
         @(posedge clk_p);
         budget++;
      end
      @(negedge clk_p);
      bus.block_ready_p = 1'b0;
   endtask

   task automatic run(input int valid_pct, input int ready_pct, input int stall);
      build_exp();
      fork
         drive(valid_pct);
         collect(exp_blk.size(), ready_pct, stall);
      join
      repeat (2) @(negedge clk_p);
   endtask

   task automatic fill_random(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
   endtask

   task automatic pulse_reset();
      #2 reset_p = 1'b1;
      #1;
      total++;
      if (bus.block_valid_p !== 1'b0) begin
         bad++; $display("FAIL async_reset_valid got=%b want=0", bus.block_valid_p);
      end
      #1 reset_p = 1'b0;
      @(negedge clk_p);
   endtask

   task automatic test_reset();
      bus.data_p = 8'h00; bus.data_valid_p = 1'b0; bus.data_last_p = 1'b0; bus.block_ready_p = 1'b0;
      reset_p = 1'b1;
      repeat (2) @(negedge clk_p);
      reset_p = 1'b0;
      @(negedge clk_p);
      total++; if (bus.data_ready_p !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.data_ready_p); end
      total++; if (bus.block_valid_p !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.block_valid_p); end
      total++; if (bus.block_last_p !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.block_last_p); end
      total++; if (bus.block_p !== 512'h0) begin bad++; $display("FAIL reset_block got=%h want=0", bus.block_p); end
`ifdef SHA_PAD_FIRST_EN
      total++; if (bus.block_first_p !== 1'b0) begin bad++; $display("FAIL reset_first got=%b want=0", bus.block_first_p); end
`endif
   endtask

   task automatic test_abcd();
      msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
      run(100, 100, 0);
      total++; if (got_blk.size() !== 1) begin bad++; $display("FAIL abcd_count got=%0d want=1", got_blk.size()); end
      if (got_blk.size() >= 1) begin
         total++; if (got_blk[0] !== ABCD_BLK) begin bad++; $display("FAIL abcd_block got=%h want=%h", got_blk[0], ABCD_BLK); end
         total++; if (got_last[0] !== 1'b1) begin bad++; $display("FAIL abcd_last got=%b want=1", got_last[0]); end
      end
      total++; if (t_valid !== t_last + 1) begin bad++; $display("FAIL abcd_latency got=%0d want=%0d", t_valid, t_last + 1); end
      total++; if (hold_viol !== 0) begin bad++; $display("FAIL abcd_hold got=%0d want=0", hold_viol); end
   endtask

   task automatic test_len55();
      msg_q.delete();
      for (int i = 0; i < 55; i++) msg_q.push_back(8'h00);
      run(100, 100, 0);
      total++; if (got_blk.size() !== 1) begin bad++; $display("FAIL len55_count got=%0d want=1", got_blk.size()); end
      if (got_blk.size() >= 1) begin
         total++; if (got_blk[0] !== {32'h000001B8, 32'h0, 32'h00000080, 416'h0}) begin
            bad++; $display("FAIL len55_block got=%h", got_blk[0]); end
         total++; if (got_last[0] !== 1'b1) begin bad++; $display("FAIL len55_last got=%b want=1", got_last[0]); end
      end
      total++; if (drv_cycles !== 55) begin bad++; $display("FAIL len55_rate got=%0d want=55", drv_cycles); end
   endtask

   task automatic test_len56();
      msg_q.delete();
      for (int i = 0; i < 56; i++) msg_q.push_back(8'h00);
      run(100, 100, 0);
      total++; if (got_blk.size() !== 2) begin bad++; $display("FAIL len56_count got=%0d want=2", got_blk.size()); end
      if (got_blk.size() >= 2) begin
         total++; if (got_blk[0] !== {32'h0, 32'h80000000, 448'h0}) begin bad++; $display("FAIL len56_blk0 got=%h", got_blk[0]); end
         total++; if (got_blk[1] !== {32'h000001C0, 480'h0}) begin bad++; $display("FAIL len56_blk1 got=%h", got_blk[1]); end
         total++; if ({got_last[0], got_last[1]} !== 2'b01) begin
            bad++; $display("FAIL len56_last got=%b%b want=01", got_last[0], got_last[1]); end
`ifdef SHA_PAD_FIRST_EN
         total++; if ({got_first[0], got_first[1]} !== 2'b10) begin
            bad++; $display("FAIL len56_first got=%b%b want=10", got_first[0], got_first[1]); end
`endif
      end
   endtask

   task automatic test_len64();
      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'hFF);
      run(100, 100, 0);
      total++; if (got_blk.size() !== 2) begin bad++; $display("FAIL len64_count got=%0d want=2", got_blk.size()); end
      if (got_blk.size() >= 2) begin
         total++; if (got_blk[0] !== {512{1'b1}}) begin bad++; $display("FAIL len64_blk0 got=%h", got_blk[0]); end
         total++; if (got_blk[1] !== {32'h00000200, 448'h0, 32'h80000000}) begin bad++; $display("FAIL len64_blk1 got=%h", got_blk[1]); end
         total++; if ({got_last[0], got_last[1]} !== 2'b01) begin
            bad++; $display("FAIL len64_last got=%b%b want=01", got_last[0], got_last[1]); end
`ifdef SHA_PAD_FIRST_EN
         total++; if ({got_first[0], got_first[1]} !== 2'b10) begin
            bad++; $display("FAIL len64_first got=%b%b want=10", got_first[0], got_first[1]); end
`endif
      end
      total++; if (t_valid !== t_last + 1) begin bad++; $display("FAIL len64_latency got=%0d want=%0d", t_valid, t_last + 1); end
   endtask

   task automatic test_backpressure();
      fill_random(70);
      run(100, 100, 20);
      total++; if (hold_viol !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", hold_viol); end
      total++; if (drv_cycles !== 91) begin bad++; $display("FAIL stall_cycles got=%0d want=91", drv_cycles); end
      total++; if (got_blk.size() !== exp_blk.size()) begin
         bad++; $display("FAIL stall_count got=%0d want=%0d", got_blk.size(), exp_blk.size()); end
      for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
         total++; if (got_blk[i] !== exp_blk[i]) begin bad++; $display("FAIL stall_block%0d got=%h want=%h", i, got_blk[i], exp_blk[i]); end
         total++; if (got_last[i] !== exp_last[i]) begin bad++; $display("FAIL stall_last%0d got=%b want=%b", i, got_last[i], exp_last[i]); end
      end
   endtask

   task automatic test_throughput();
      fill_random(130);
      run(100, 100, 0);
      total++; if (drv_cycles !== 132) begin bad++; $display("FAIL rate130_cycles got=%0d want=132", drv_cycles); end
      total++; if (got_blk.size() !== exp_blk.size()) begin
         bad++; $display("FAIL rate130_count got=%0d want=%0d", got_blk.size(), exp_blk.size()); end
      for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
         total++; if (got_blk[i] !== exp_blk[i]) begin bad++; $display("FAIL rate130_block%0d got=%h want=%h", i, got_blk[i], exp_blk[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bus.block_ready_p = 1'b0;
      fill_random(10);
      drive(100);
      pulse_reset();
      fill_random(64);
      drive(100);
      @(negedge clk_p);
      total++; if (bus.block_valid_p !== 1'b1) begin bad++; $display("FAIL held_valid got=%b want=1", bus.block_valid_p); end
      pulse_reset();
      total++; if (bus.data_ready_p !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", bus.data_ready_p); end
      msg_q = '{8'h61, 8'h62, 8'h63, 8'h64};
      run(100, 100, 0);
      total++; if (got_blk.size() !== 1) begin bad++; $display("FAIL rst_abcd_count got=%0d want=1", got_blk.size()); end
      if (got_blk.size() >= 1) begin
         total++; if (got_blk[0] !== ABCD_BLK) begin bad++; $display("FAIL rst_abcd_block got=%h want=%h", got_blk[0], ABCD_BLK); end
         total++; if (got_last[0] !== 1'b1) begin bad++; $display("FAIL rst_abcd_last got=%b want=1", got_last[0]); end
      end
   endtask

   task automatic test_messages(input string tag, input int n_msg, input int fixed_len[$],
                                input int valid_pct, input int ready_pct);
      for (int m = 0; m < n_msg; m++) begin
         fill_random(fixed_len.size() > m ? fixed_len[m] : int'($urandom_range(200, 1)));
         run(valid_pct, ready_pct, 0);
         total++; if (got_blk.size() !== exp_blk.size()) begin
            bad++; $display("FAIL %s_count len=%0d got=%0d want=%0d", tag, msg_q.size(), got_blk.size(), exp_blk.size()); end
         for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            total++; if (got_blk[i] !== exp_blk[i]) begin
               bad++; $display("FAIL %s_block len=%0d blk=%0d got=%h want=%h", tag, msg_q.size(), i, got_blk[i], exp_blk[i]); end
            total++; if (got_last[i] !== exp_last[i]) begin
               bad++; $display("FAIL %s_last len=%0d blk=%0d got=%b want=%b", tag, msg_q.size(), i, got_last[i], exp_last[i]); end
`ifdef SHA_PAD_FIRST_EN
            total++; if (got_first[i] !== exp_first[i]) begin
               bad++; $display("FAIL %s_first len=%0d blk=%0d got=%b want=%b", tag, msg_q.size(), i, got_first[i], exp_first[i]); end
`endif
         end
         total++; if (hold_viol !== 0) begin bad++; $display("FAIL %s_hold len=%0d got=%0d want=0", tag, msg_q.size(), hold_viol); end
         total++; if (drv_sent !== msg_q.size()) begin
            bad++; $display("FAIL %s_sent got=%0d want=%0d", tag, drv_sent, msg_q.size()); end
         total++; if (bus.block_valid_p !== 1'b0) begin bad++; $display("FAIL %s_idle got=%b want=0", tag, bus.block_valid_p); end
      end
   endtask

   initial begin
      test_reset();
      test_abcd();
      test_len55();
      test_len56();
      test_len64();
      test_backpressure();
      test_throughput();
      test_reset_mid();
      test_messages("boundary", 10, '{1, 54, 55, 56, 62, 63, 64, 65, 127, 128}, 90, 80);
      test_messages("random", 8, '{}, 75, 60);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha_padder.md
SHA_PADDER -- requirements
Module: sha_padder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; no parameters.
REQ-002 clk_p  in  1  rising-edge clock.
REQ-003 reset_p  in  1  async active-high reset.
REQ-004 data_p  in  8  message byte, first byte of message first.
REQ-005 data_valid_p  in  1  data_p valid.
REQ-006 data_last_p  in  1  qualifies data_p as final byte of message.
REQ-007 data_ready_p  out  1  padder accepts byte this cycle.
REQ-008 block_p  out  512  padded block, word i at bits [32i+31:32i], bytes big-endian within word.
REQ-009 block_valid_p  out  1  block_p valid.
REQ-010 block_ready_p  in  1  hash core (sha_algo) consumes block.
REQ-011 block_last_p  out  1  block_p is final block of message.

Function
REQ-012 Byte transfer SHALL occur when data_valid_p and data_ready_p are high on a rising edge; block transfer when block_valid_p and block_ready_p are high.
REQ-013 FSM states SHALL be ACCUM, EMIT, LEN; reset state ACCUM.
REQ-014 ACCUM: data_ready_p=1, block_valid_p=0; byte n of block (0..63) written to word n/4, byte lane 3-(n%4); 64-bit bit counter += 8 per accepted byte.
REQ-015 ACCUM, 64th byte accepted, not last -> EMIT with block_last_p=0.
REQ-016 ACCUM, last byte accepted at block index k: 0x80 SHALL be placed at k+1 when k<63, zeros fill remainder; if k<=54, word 14 = counter[63:32], word 15 = counter[31:0], block_last_p=1 -> EMIT; else block_last_p=0, -> EMIT then LEN.
REQ-017 Last byte at k=63: current block emitted unpadded, block_last_p=0; following LEN block SHALL hold 0x80 at byte 0.
REQ-018 LEN block: 0x80 at byte 0 only when REQ-017 applies, otherwise zeros; words 14/15 = bit length; block_last_p=1.
REQ-019 EMIT/LEN: data_ready_p=0; block_p, block_valid_p, block_last_p SHALL stay stable until transfer; transfer from EMIT goes to LEN if pending, else ACCUM with buffer and (after last block) counter cleared.
REQ-020 Bit counter SHALL wrap modulo 2^64; zero-length messages are not representable (data_last_p requires a byte).
REQ-021 Throughput: one byte per cycle in ACCUM; first byte of next block accepted cycle after block transfer; block_valid_p rises cycle after final accepted byte.
REQ-022 data_last_p SHALL be ignored unless data_valid_p and data_ready_p.

Reset
REQ-023 reset_p SHALL asynchronously force ACCUM, buffer=0, counter=0, block_valid_p=0, block_last_p=0, data_ready_p=1 after release; reset mid-message discards partial message and any held block.

Configuration
REQ-024 Macro SHA_PAD_FIRST_EN defined: extra output block_first_p (1 bit), high with the first block of each message (IV reload for sha_algo), stable with block_p, reset 0.
REQ-025 Macro undefined: port block_first_p absent; all other behaviour identical.

Structure
REQ-026 Shared package sha_pkg SHALL hold SHA_BLOCK_W=512, SHA_WORD_W=32, SHA_LEN_W=64, SHA_PAD_BYTE=8'h80, LEN_LIMIT=55, and state encoding.
REQ-027 Single module, no sub-module; output connects directly to sha_algo message_p/message_valid_p/message_ready_p.

Verification
REQ-028 "abcd" (61,62,63,64, last on 64), ready=1 -> one block 512'h00000020_00000000_..._80000000_61626364, last=1.
REQ-029 55 bytes 0x00 -> one block, byte 55=0x80, word15=0x000001B8, last=1.
REQ-030 56 bytes 0x00 -> block1 byte56=0x80, last=0; block2 zeros, word15=0x000001C0, last=1.
REQ-031 64 bytes 0xFF -> block1 all 0xFF, last=0; block2 word0=0x80000000, word15=0x00000200, last=1.
REQ-032 block_ready_p low 20 cycles during EMIT -> block_p/valid stable, data_ready_p=0, no byte lost.
REQ-033 reset_p pulsed after 10 bytes, then "abcd" -> output identical to REQ-028; with SHA_PAD_FIRST_EN, block_first_p=1 only on first block of REQ-030/031.
